// File: rtl/axi_lite_slv_mem.sv
// AXI4-Lite slave with a byte-strobed, word-addressed register memory.
// Independent write/read FSMs; all outputs are driven from flops only.
module axi_lite_slv_mem #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);
    localparam int unsigned IDXW  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * BYTES);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic                    live_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BYTES-1:0]        wstrb_q;
    logic [1:0]              bresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0]   c_addr, w_off, r_off;
    logic [DATA_WIDTH-1:0]   c_data;
    logic [BYTES-1:0]        c_strb;
    logic                    w_in, r_in;
    logic [IDXW-1:0]         w_idx, r_idx;
    logic                    unused_bits;

    // live_q holds the readies low until the first edge after reset
    assign s_axi_awready = live_q & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_D));
    assign s_axi_wready  = live_q & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_A));
    assign s_axi_bvalid  = (wstate_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = live_q & (rstate_q == R_IDLE);
    assign s_axi_rvalid  = (rstate_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    assign c_addr = (wstate_q == W_HAVE_A) ? awaddr_q : s_axi_awaddr;
    assign c_data = (wstate_q == W_HAVE_D) ? wdata_q : s_axi_wdata;
    assign c_strb = (wstate_q == W_HAVE_D) ? wstrb_q : s_axi_wstrb;

    // Wrapping subtraction makes addresses below BASE_ADDR fall out of range
    assign w_off = c_addr - BASE_ADDR;
    assign w_in  = (w_off < SPAN);
    assign w_idx = w_off[OFFW +: IDXW];
    assign r_off = s_axi_araddr - BASE_ADDR;
    assign r_in  = (r_off < SPAN);
    assign r_idx = r_off[OFFW +: IDXW];

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, w_off, r_off};

    always_comb begin
        wstate_d = wstate_q;
        commit   = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end else if (aw_hs) begin
                    wstate_d = W_HAVE_A;
                end else if (w_hs) begin
                    wstate_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        unique case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (s_axi_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            live_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            live_q   <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
        end else begin
            if (aw_hs) awaddr_q <= s_axi_awaddr;
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (commit) bresp_q <= w_in ? OKAY : SLVERR;
        end
    end

    // Read samples mem_q before this edge's write lands: old data on collision
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (ar_hs) begin
            rdata_q <= r_in ? mem_q[r_idx] : '0;
            rresp_q <= r_in ? OKAY : SLVERR;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem_q <= '{default: '0};
        end else if (commit && w_in) begin
            for (int b = 0; b < BYTES; b++) begin
                if (c_strb[b]) mem_q[w_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/axi_lite_slv_mem.md
# axi_lite_slv_mem

AXI4-Lite slave responder with an internal word-addressed memory, the responding end of the AXI master stimulus path in the `chip` design. It accepts write and read transactions from an AXI master (VIP master agent or RTL master), stores data with byte-strobe granularity, and returns OKAY/SLVERR responses. It replaces the VIP passthrough slave memory model in synthesizable builds.

## Interface

- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: data width, 32 or 64 only.
- `DEPTH`, 16: memory words, power of two, 2..1024.
- `BASE_ADDR`, 0: byte address of word 0, aligned to `DEPTH*DATA_WIDTH/8`.

- `aclk`  in  1  clock; all logic rising-edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_axi_awaddr`  in  ADDR_WIDTH  write address.
- `s_axi_awprot`  in  3  ignored.
- `s_axi_awvalid` / `s_axi_awready`  in/out  1  AW handshake.
- `s_axi_wdata`  in  DATA_WIDTH  write data.
- `s_axi_wstrb`  in  DATA_WIDTH/8  byte enables.
- `s_axi_wvalid` / `s_axi_wready`  in/out  1  W handshake.
- `s_axi_bresp`  out  2  write response.
- `s_axi_bvalid` / `s_axi_bready`  out/in  1  B handshake.
- `s_axi_araddr`  in  ADDR_WIDTH  read address.
- `s_axi_arprot`  in  3  ignored.
- `s_axi_arvalid` / `s_axi_arready`  in/out  1  AR handshake.
- `s_axi_rdata`  out  DATA_WIDTH  read data.
- `s_axi_rresp`  out  2  read response.
- `s_axi_rvalid` / `s_axi_rready`  out/in  1  R handshake.

## Operation

- Address decode: offset = addr − BASE_ADDR; word index = offset >> log2(DATA_WIDTH/8); low byte-offset bits ignored (no unaligned error). Offset ≥ DEPTH*DATA_WIDTH/8 (including addr < BASE_ADDR wrapping) → out of range.
- Write FSM states: W_IDLE (awready=1, wready=1), W_HAVE_A (awready=0, wready=1), W_HAVE_D (awready=1, wready=0), W_RESP (both 0, bvalid=1).
  - W_IDLE: AW and W same cycle → commit, W_RESP; AW only → latch addr, W_HAVE_A; W only → latch data/strb, W_HAVE_D.
  - W_HAVE_A on W handshake, W_HAVE_D on AW handshake → commit, W_RESP.
  - W_RESP: hold bvalid and bresp stable until bready; then W_IDLE.
- Commit: in range → bytes with wstrb=1 updated, bresp=OKAY (2'b00); out of range → no memory change, bresp=SLVERR (2'b10). wstrb=0 in range is legal: no change, OKAY.
- Read FSM states: R_IDLE (arready=1), R_DATA (arready=0, rvalid=1).
  - AR handshake: memory sampled, rdata/rresp registered, R_DATA. Out of range → rdata=0, rresp=SLVERR.
  - R_DATA: hold rdata/rresp stable until rready; then R_IDLE.
- Read and write channels are independent; no ordering between them.
- Same-cycle write commit and read accept to same word: read returns pre-write value.
- Reset: all memory words cleared to 0; FSMs to W_IDLE/R_IDLE.

## Timing

- Reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0. Ready outputs rise on first clock edge after areset deasserts (state-derived, registered).
- Write: bvalid asserted the cycle after the completing AW/W handshake. Memory updated at that same edge.
- Read: rvalid asserted the cycle after AR handshake (1-cycle latency).
- Max throughput: one write per 2 cycles, one read per 2 cycles (ready low during response phase).
- No combinational path from any input to any output.
- areset asserted mid-transaction: transaction aborted, bvalid/rvalid drop asynchronously, no response issued after reset; partially latched AW or W discarded.
- Valid outputs never depend on ready inputs (AXI rule); once asserted, held until handshake.

## Test plan

- Reset: hold areset 5 cycles → all outputs 0; after release, awready=wready=arready=1; read of word 3 returns 0x00000000, OKAY.
- Write 0xDEADBEEF to BASE_ADDR+0x8, strb 0xF, AW and W same cycle → bvalid next cycle, OKAY; read 0x8 → 0xDEADBEEF, rvalid 1 cycle after AR.
- Byte strobe: write 0x11223344 strb 0x5 over 0xDEADBEEF → read returns 0xDE22BE44.
- Channel ordering: W 3 cycles before AW, then AW 3 cycles before W on another word; bready held low 4 cycles → bvalid/bresp stable, awready=wready=0 throughout, both writes land.
- Out of range: write/read BASE_ADDR+DEPTH*4 (DEPTH=16: 0x40) → bresp=SLVERR, rresp=SLVERR, rdata=0; memory unchanged; address BASE_ADDR−4 also SLVERR.
- Collision and reset: same-cycle write commit and AR to word 2 (old 0xA, new 0xB) → read returns 0xA, next read 0xB; assert areset while rvalid=1 and rready=0 → rvalid drops immediately, memory reads 0 afterwards.
